// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between the fetch and data ports
// Define MEM_ARB_RR_EN for round-robin resolution of contested grants (default: fixed data priority).
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_width,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_width,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SRV_IF = 2'd1,
    SRV_D  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [2:0] FETCH_WIDTH = 3'b010;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          mem_width_q, mem_width_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [7:0]          wait_q, wait_d;
  logic                pick_d;
  logic                finish;
  logic [DATA_W-1:0]   resp_data;

`ifdef MEM_ARB_RR_EN
  // 1 = data port was served last; resets to fetch so the first contest goes to data
  logic                last_d_q, last_d_d;

  always_comb begin
    pick_d = d_req & (~if_req | ~last_d_q);
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_width_d = mem_width_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    wait_d      = wait_q;
    finish      = 1'b0;
    resp_data   = '0;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = SRV_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_width_d = d_width;
          wait_d      = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (if_req) begin
          state_d     = SRV_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_width_d = FETCH_WIDTH;
          wait_d      = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end

      SRV_IF, SRV_D: begin
        // A ready on the final wait cycle still counts as a completion
        if (mem_ready) begin
          finish    = 1'b1;
          resp_data = mem_rdata;
        end else if (wait_q == MAX_WAIT_C) begin
          finish    = 1'b1;
          err_d     = 1'b1;
        end else begin
          wait_d    = wait_q + 8'd1;
        end

        if (finish) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_width_d = '0;
          if (state_q == SRV_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp_data;
          end else begin
            d_rvalid_d  = 1'b1;
            d_rdata_d   = mem_we_q ? '0 : resp_data;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_width_q <= mem_width_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_width = mem_width_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_rvalid_q;
  assign stall_d   = d_req & ~d_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
// Expected arbitration follows MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 15;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [2:0]    d_width = '0;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_width;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if;
  logic          stall_d;
  logic          err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_err = 1'b0;
  bit rr_last_d = 1'b0;

  // transaction-level model state for the randomized phase
  int            k;
  int            idle_from;
  int            c_edge;
  bit            active;
  bit            act_d;
  bit            act_we;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_wdata;
  logic [2:0]    act_width;
  bit            exp_if_rv;
  bit            exp_d_rv;
  bit            win_d;
  logic [AW-1:0] cur_if_addr;
  logic [AW-1:0] cur_d_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Grant on the next edge, hold off mem_ready for 'waits' cycles (or forever when tmo), check the response
  task automatic serve(input bit is_d, input logic [AW-1:0] addr, input bit we,
                       input logic [DW-1:0] wdata, input logic [2:0] width,
                       input int waits, input logic [DW-1:0] rdata, input bit tmo);
    int ncyc;
    ncyc = tmo ? MAXW + 1 : waits + 1;
    step();
    for (int i = 0; i < ncyc; i++) begin
      chk("srv_mem_req", 64'(mem_req), 64'(1'b1));
      chk("srv_mem_addr", 64'(mem_addr), 64'(addr));
      chk("srv_mem_we", 64'(mem_we), 64'(is_d & we));
      if (is_d) begin
        chk("srv_mem_wdata", 64'(mem_wdata), 64'(wdata));
        chk("srv_mem_width", 64'(mem_width), 64'(width));
        chk("srv_stall_d", 64'(stall_d), 64'(1'b1));
      end else begin
        chk("srv_stall_if", 64'(stall_if), 64'(1'b1));
      end
      mem_ready = !tmo && (i == waits);
      mem_rdata = mem_ready ? rdata : DW'($urandom);
      step();
    end
    mem_ready = 1'b0;
    mem_rdata = DW'($urandom);
    if (tmo) exp_err = 1'b1;
    rr_last_d = is_d;
    chk("done_mem_req", 64'(mem_req), 64'(1'b0));
    chk("done_mem_we", 64'(mem_we), 64'(1'b0));
    chk("done_if_rvalid", 64'(if_rvalid), 64'(!is_d));
    chk("done_d_rvalid", 64'(d_rvalid), 64'(is_d));
    chk("done_err", 64'(err), 64'(exp_err));
    if (is_d) begin
      chk("done_d_rdata", 64'(d_rdata), 64'((we || tmo) ? 32'h0 : rdata));
      chk("done_stall_d", 64'(stall_d), 64'(1'b0));
    end else begin
      chk("done_if_rdata", 64'(if_rdata), 64'(tmo ? 32'h0 : rdata));
      chk("done_stall_if", 64'(stall_if), 64'(1'b0));
    end
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata), 64'(0));
    chk("rst_d_rdata", 64'(d_rdata), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b1;

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    step();
    chk("idle_ready_mem_req", 64'(mem_req), 64'(0));
    chk("idle_ready_if_rvalid", 64'(if_rvalid), 64'(0));
    mem_ready = 1'b0;

    // fetch, ready on first service cycle
    if_req = 1'b1;
    if_addr = 32'h0BFC_0000;
    serve(1'b0, 32'h0BFC_0000, 1'b0, '0, 3'b010, 0, 32'h0050_0093, 1'b0);
    if_req = 1'b0;
    step();
    chk("t1_rvalid_pulse", 64'(if_rvalid), 64'(0));
    chk("t1_stall_if_after", 64'(stall_if), 64'(0));

    // store with three wait cycles; mem_rdata is junk and must not leak into d_rdata
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hA5A5_A5A5; d_width = 3'b010;
    serve(1'b1, 32'h100, 1'b1, 32'hA5A5_A5A5, 3'b010, 3, 32'hDEAD_BEEF, 1'b0);
    d_req = 1'b0;
    step();

    // contested grants
    cur_if_addr = 32'h200;
    cur_d_addr  = 32'h300;
    if_req = 1'b1; if_addr = cur_if_addr;
    d_req = 1'b1; d_we = 1'b0; d_addr = cur_d_addr; d_width = 3'b010;
    for (int r = 0; r < 4; r++) begin
      win_d = RR ? !rr_last_d : 1'b1;
      if (win_d) begin
        serve(1'b1, cur_d_addr, 1'b0, d_wdata, 3'b010, r, mem_word(cur_d_addr), 1'b0);
        cur_d_addr = cur_d_addr + 32'd4;
        d_addr = cur_d_addr;
      end else begin
        serve(1'b0, cur_if_addr, 1'b0, '0, 3'b010, r, mem_word(cur_if_addr), 1'b0);
        cur_if_addr = cur_if_addr + 32'd4;
        if_addr = cur_if_addr;
      end
      step();
    end
    d_req = 1'b0;
    serve(1'b0, cur_if_addr, 1'b0, '0, 3'b010, 1, mem_word(cur_if_addr), 1'b0);
    if_req = 1'b0;
    step();

    // fetch dropped mid-access still completes; a data request arriving meanwhile waits
    if_req = 1'b1; if_addr = 32'h0BFC_0004;
    step();
    chk("drop_mem_req", 64'(mem_req), 64'(1));
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h540; d_width = 3'b000;
    step();
    chk("drop_still_fetch", 64'(mem_addr), 64'(32'h0BFC_0004));
    chk("drop_stall_d", 64'(stall_d), 64'(1));
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    chk("drop_if_rvalid", 64'(if_rvalid), 64'(1));
    chk("drop_if_rdata", 64'(if_rdata), 64'(32'h1234_5678));
    chk("drop_stall_d_held", 64'(stall_d), 64'(1));
    rr_last_d = 1'b0;
    step();
    serve(1'b1, 32'h540, 1'b0, d_wdata, 3'b000, 2, 32'hCAFE_F00D, 1'b0);
    d_req = 1'b0;
    step();

    // ready on the same cycle the wait count reaches MAX_WAIT: normal completion
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_width = 3'b010;
    serve(1'b1, 32'h600, 1'b0, d_wdata, 3'b010, MAXW, 32'h0BAD_F00D, 1'b0);
    d_req = 1'b0;
    step();

    // timeout on fetch, then a good access with err still set
    if_req = 1'b1; if_addr = 32'h0000_0700;
    serve(1'b0, 32'h700, 1'b0, '0, 3'b010, 0, 32'h0, 1'b1);
    if_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h0F0F_0F0F; d_width = 3'b001;
    serve(1'b1, 32'h800, 1'b1, 32'h0F0F_0F0F, 3'b001, 1, 32'h0, 1'b0);
    d_req = 1'b0;
    step();

    // reset mid data access, then re-arbitrate the still-held request
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_width = 3'b010;
    step();
    chk("rst_mid_mem_req_before", 64'(mem_req), 64'(1));
    step();
    rst = 1'b0;
    #1;
    exp_err = 1'b0;
    rr_last_d = 1'b0;
    chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mid_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("rst_mid_err", 64'(err), 64'(0));
    step();
    chk("rst_mid_no_rvalid", 64'(d_rvalid), 64'(0));
    rst = 1'b1;
    serve(1'b1, 32'h400, 1'b0, d_wdata, 3'b010, 0, 32'h7777_1111, 1'b0);
    d_req = 1'b0;
    step();
    step();
    step();

    // randomized traffic against a transaction-level schedule
    active = 1'b0;
    idle_from = 0;
    for (k = 1; k <= 700; k++) begin
      step();
      exp_if_rv = 1'b0;
      exp_d_rv  = 1'b0;
      if (active && k == c_edge) begin
        active = 1'b0;
        if (act_d) exp_d_rv = 1'b1;
        else exp_if_rv = 1'b1;
        idle_from = k + 2;
      end else if (!active && k >= idle_from && (if_req || d_req)) begin
        win_d = d_req && (!if_req || !RR || !rr_last_d);
        act_d = win_d;
        act_we = win_d ? d_we : 1'b0;
        act_addr = win_d ? d_addr : if_addr;
        act_wdata = d_wdata;
        act_width = d_width;
        c_edge = k + 1 + int'($urandom_range(0, 5));
        active = 1'b1;
        rr_last_d = win_d;
      end

      chk("rnd_mem_req", 64'(mem_req), 64'(active));
      if (active) begin
        chk("rnd_mem_addr", 64'(mem_addr), 64'(act_addr));
        chk("rnd_mem_we", 64'(mem_we), 64'(act_we));
        if (act_d) begin
          chk("rnd_mem_wdata", 64'(mem_wdata), 64'(act_wdata));
          chk("rnd_mem_width", 64'(mem_width), 64'(act_width));
        end
      end
      chk("rnd_if_rvalid", 64'(if_rvalid), 64'(exp_if_rv));
      chk("rnd_d_rvalid", 64'(d_rvalid), 64'(exp_d_rv));
      if (exp_if_rv) chk("rnd_if_rdata", 64'(if_rdata), 64'(mem_word(act_addr)));
      if (exp_d_rv) chk("rnd_d_rdata", 64'(d_rdata), 64'(act_we ? 32'h0 : mem_word(act_addr)));
      chk("rnd_stall_if", 64'(stall_if), 64'(if_req && !exp_if_rv));
      chk("rnd_stall_d", 64'(stall_d), 64'(d_req && !exp_d_rv));
      chk("rnd_err", 64'(err), 64'(0));

      if (exp_if_rv || (!if_req && $urandom_range(0, 3) == 0)) begin
        if_req = exp_if_rv ? 1'(($urandom_range(0, 1))) : 1'b1;
        if_addr = AW'($urandom) & ~32'h3;
      end
      if (exp_d_rv || (!d_req && $urandom_range(0, 3) == 0)) begin
        d_req = exp_d_rv ? 1'(($urandom_range(0, 1))) : 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom);
        d_wdata = DW'($urandom);
        d_width = 3'($urandom_range(0, 7));
      end
      if (active) mem_ready = (k == c_edge - 1);
      else mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = (active && mem_ready) ? mem_word(act_addr) : DW'($urandom);
    end

    if_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
